// File: rtl/uart_boot_loader.sv
// UART program loader: holds the core in reset, receives a length-prefixed program,
// writes it to memory, sends an ack byte, then passes core memory traffic through.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter logic [31:0] MAX_WORDS = 32'd16384,
  parameter logic [7:0]  DONE_BYTE = 8'hAA,
  parameter logic [7:0]  ERR_BYTE  = 8'hEE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic [31:0] core_adr,
  input  logic [31:0] core_writedata,
  input  logic        core_memwrite,
  output logic [31:0] core_readdata,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_writedata,
  output logic        mem_memwrite,
  input  logic [31:0] mem_readdata,
  output logic        core_rstn,
  output logic        busy
);

  typedef enum logic [2:0] {StLen, StData, StAck, StRun, StErr} state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] len_q, len_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] wr_adr_q, wr_adr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic        err_q, err_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        core_rstn_q, core_rstn_d;

  logic [31:0] word;
  logic [31:0] idx_inc;
  logic        last_byte;

  // Bytes shift in from the top so the first byte of a group ends up in bits [7:0].
  assign word      = {rx_data, asm_q};
  assign idx_inc   = idx_q + 32'd1;
  assign last_byte = (byte_cnt_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    len_d       = len_q;
    idx_d       = idx_q;
    wr_adr_d    = wr_adr_q;
    wr_data_d   = wr_data_q;
    wr_pulse_d  = 1'b0;
    err_d       = err_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;

    if (rx_valid && (state_q == StLen || state_q == StData)) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      asm_d      = {rx_data, asm_q[23:8]};
    end

    unique case (state_q)
      StLen: begin
        if (rx_valid && last_byte) begin
          len_d = word;
          idx_d = 32'd0;
          if (word == 32'd0) begin
            state_d    = StAck;
            tx_valid_d = 1'b1;
            tx_data_d  = DONE_BYTE;
          end else if (word > MAX_WORDS) begin
            state_d    = StAck;
            err_d      = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = ERR_BYTE;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (rx_valid && last_byte) begin
          wr_adr_d   = BASE_ADR + (idx_q << 2);
          wr_data_d  = word;
          wr_pulse_d = 1'b1;
          idx_d      = idx_inc;
          if (idx_inc == len_q) begin
            state_d    = StAck;
            tx_valid_d = 1'b1;
            tx_data_d  = DONE_BYTE;
          end
        end
      end
      StAck: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = err_q ? StErr : StRun;
        end
      end
      StRun, StErr: ;
      default: state_d = StLen;
    endcase

    core_rstn_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StLen;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 24'd0;
      len_q       <= 32'd0;
      idx_q       <= 32'd0;
      wr_adr_q    <= 32'd0;
      wr_data_q   <= 32'd0;
      wr_pulse_q  <= 1'b0;
      err_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      core_rstn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      wr_adr_q    <= wr_adr_d;
      wr_data_q   <= wr_data_d;
      wr_pulse_q  <= wr_pulse_d;
      err_q       <= err_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      core_rstn_q <= core_rstn_d;
    end
  end

  always_comb begin
    busy          = (state_q != StRun);
    tx_valid      = tx_valid_q;
    tx_data       = tx_data_q;
    core_rstn     = core_rstn_q;
    core_readdata = mem_readdata;
    if (busy) begin
      mem_adr       = wr_adr_q;
      mem_writedata = wr_data_q;
      mem_memwrite  = wr_pulse_q;
    end else begin
      mem_adr       = core_adr;
      mem_writedata = core_writedata;
      mem_memwrite  = core_memwrite;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: expected writes and ack bytes come from a
// byte-stream model; a per-cycle monitor checks the memory port against it.
module tb_uart_boot_loader;

  localparam logic [31:0] MaxWords = 32'd16384;
  localparam logic [7:0]  DoneByte = 8'hAA;
  localparam logic [7:0]  ErrByte  = 8'hEE;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [31:0] core_adr = 32'd0;
  logic [31:0] core_writedata = 32'd0;
  logic        core_memwrite = 1'b0;
  logic [31:0] core_readdata;
  logic [31:0] mem_adr;
  logic [31:0] mem_writedata;
  logic        mem_memwrite;
  logic [31:0] mem_readdata = 32'd0;
  logic        core_rstn;
  logic        busy;

  uart_boot_loader #(
    .BASE_ADR (32'h0000_0000),
    .MAX_WORDS(MaxWords),
    .DONE_BYTE(DoneByte),
    .ERR_BYTE (ErrByte)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .tx_ready      (tx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .core_adr      (core_adr),
    .core_writedata(core_writedata),
    .core_memwrite (core_memwrite),
    .core_readdata (core_readdata),
    .mem_adr       (mem_adr),
    .mem_writedata (mem_writedata),
    .mem_memwrite  (mem_memwrite),
    .mem_readdata  (mem_readdata),
    .core_rstn     (core_rstn),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_readdata <= $urandom();

  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;
  logic [63:0] exp_wr[$];  // {address, data} of each write still expected
  logic [7:0]  stim[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle, compare the memory/core ports against the model.
  always @(negedge clk) begin
    logic [63:0] e;
    if (chk_en) begin
      check("readdata_pass", {32'd0, core_readdata}, {32'd0, mem_readdata});
      check("core_rstn_vs_busy", {63'd0, core_rstn}, {63'd0, !busy});
      if (!busy) begin
        check("run_adr", {32'd0, mem_adr}, {32'd0, core_adr});
        check("run_wdata", {32'd0, mem_writedata}, {32'd0, core_writedata});
        check("run_we", {63'd0, mem_memwrite}, {63'd0, core_memwrite});
      end else if (mem_memwrite) begin
        if (exp_wr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %h@%h, required no write", mem_writedata, mem_adr);
        end else begin
          e = exp_wr.pop_front();
          check("wr_adr", {32'd0, mem_adr}, {32'd0, e[63:32]});
          check("wr_data", {32'd0, mem_writedata}, {32'd0, e[31:0]});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stim();
    foreach (stim[i]) send_byte(stim[i]);
  endtask

  // Model: length word is little-endian; words land at BASE + 4*i; oversize -> error ack.
  task automatic model_expect(output logic [7:0] ack);
    logic [31:0] len;
    len = {stim[3], stim[2], stim[1], stim[0]};
    if (len > MaxWords) ack = ErrByte;
    else begin
      ack = DoneByte;
      for (int w = 0; w < int'(len); w++)
        exp_wr.push_back({32'(4 * w), stim[4*w+7], stim[4*w+6], stim[4*w+5], stim[4*w+4]});
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn          = 1'b0;
    rx_valid      = 1'b0;
    tx_ready      = 1'b0;
    #1;
    check("rst_core_rstn", {63'd0, core_rstn}, 64'd0);
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_memwrite", {63'd0, mem_memwrite}, 64'd0);
    exp_wr.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Waits (bounded) for the ack, holds tx_ready low for 'hold' cycles, then handshakes.
  task automatic wait_tx(input logic [7:0] exp, input int hold, input logic exp_run);
    int n = 0;
    @(negedge clk);
    while (!tx_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("tx_seen", {63'd0, tx_valid}, 64'd1);
    check("tx_byte", {56'd0, tx_data}, {56'd0, exp});
    repeat (hold) begin
      @(negedge clk);
      check("tx_hold_valid", {63'd0, tx_valid}, 64'd1);
      check("tx_hold_data", {56'd0, tx_data}, {56'd0, exp});
      check("tx_hold_core_rstn", {63'd0, core_rstn}, 64'd0);
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("tx_drop", {63'd0, tx_valid}, 64'd0);
    check("core_rstn_after_ack", {63'd0, core_rstn}, {63'd0, exp_run});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ack;
    chk_en = 1'b1;

    // Two-word load with hand-computed writes; stray core stores must be ignored.
    do_reset();
    core_adr       = 32'hFFFF_FFF0;
    core_writedata = 32'h1111_2222;
    core_memwrite  = 1'b1;
    exp_wr.push_back({32'h0000_0000, 32'h1234_5678});
    exp_wr.push_back({32'h0000_0004, 32'hDEAD_BEEF});
    stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stim();
    core_memwrite = 1'b0;
    wait_tx(8'hAA, 20, 1'b1);
    check("s1_writes_done", 64'(exp_wr.size()), 64'd0);

    // Three-word load, expectations from the model.
    do_reset();
    stim = {8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
            8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h10, 8'h32, 8'h54, 8'h76};
    model_expect(ack);
    send_stim();
    wait_tx(ack, 3, 1'b1);
    check("s2_writes_done", 64'(exp_wr.size()), 64'd0);

    // Zero length: no writes, done ack, core released.
    do_reset();
    stim = {8'h00, 8'h00, 8'h00, 8'h00};
    send_stim();
    wait_tx(8'hAA, 0, 1'b1);

    // Pass-through in run mode; rx is ignored.
    @(posedge clk); #1;
    core_adr       = 32'h0000_0100;
    core_writedata = 32'hCAFE_F00D;
    core_memwrite  = 1'b1;
    @(negedge clk);
    check("run_adr_lit", {32'd0, mem_adr}, 64'h100);
    check("run_wdata_lit", {32'd0, mem_writedata}, 64'hCAFE_F00D);
    check("run_we_lit", {63'd0, mem_memwrite}, 64'd1);
    send_byte(8'h55);
    send_byte(8'h01);
    @(negedge clk);
    check("run_busy", {63'd0, busy}, 64'd0);
    check("run_core_rstn", {63'd0, core_rstn}, 64'd1);
    check("run_tx_quiet", {63'd0, tx_valid}, 64'd0);
    core_memwrite = 1'b0;

    // Oversize length: error ack, core stays in reset, later bytes never written.
    do_reset();
    stim = {8'h01, 8'h40, 8'h00, 8'h00};
    model_expect(ack);
    send_stim();
    wait_tx(8'hEE, 0, 1'b0);
    stim = {8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stim();
    @(negedge clk);
    check("err_busy", {63'd0, busy}, 64'd1);
    check("err_core_rstn", {63'd0, core_rstn}, 64'd0);
    check("err_tx_quiet", {63'd0, tx_valid}, 64'd0);
    check("err_ack_model", {56'd0, ack}, 64'hEE);

    // Reset mid-load, then a fresh one-word load.
    do_reset();
    exp_wr.push_back({32'h0000_0000, 32'h4433_2211});
    stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stim();
    check("mid_first_write", 64'(exp_wr.size()), 64'd0);
    do_reset();
    stim = {8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hD0, 8'hFE, 8'hCA};
    model_expect(ack);
    send_stim();
    wait_tx(ack, 0, 1'b1);
    check("mid_reload_done", 64'(exp_wr.size()), 64'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
